// File: rtl/song_sequencer.sv
// ============================================================================
// Module      : song_sequencer
// Description : Happy Birthday melody sequencer. Walks a fixed 25-note ROM and
//               drives one-hot enables into the per-pitch divider bank, with a
//               silent articulation gap at the end of every note.
//               Optional macro SONG_LOOP_EN adds a 'loop' input that restarts
//               the song after the last note instead of returning to idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module song_sequencer #(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
`ifdef SONG_LOOP_EN
    input  logic       loop,
`endif
    output logic [7:0] pitch_en,
    output logic [4:0] note_idx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Duration classes stored in the ROM instead of raw tick counts
    localparam logic [1:0] C_DUR1 = 2'd0;
    localparam logic [1:0] C_DUR3 = 2'd1;
    localparam logic [1:0] C_DUR4 = 2'd2;
    localparam logic [1:0] C_DUR8 = 2'd3;

    localparam int C_CNT_W = $clog2(8 * TICK_CYCLES);

    // Terminal counts (target minus one), folded to constants per duration
    localparam logic [C_CNT_W-1:0] C_TONE1_LAST = C_CNT_W'(1 * TICK_CYCLES - GAP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TONE3_LAST = C_CNT_W'(3 * TICK_CYCLES - GAP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TONE4_LAST = C_CNT_W'(4 * TICK_CYCLES - GAP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TONE8_LAST = C_CNT_W'(8 * TICK_CYCLES - GAP_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_GAP_LAST   = C_CNT_W'(GAP_CYCLES - 1);

    localparam logic [4:0] C_LAST_NOTE = 5'd24;

    // ROM entry: {pitch code[3:0], duration class[1:0]}
    function automatic logic [5:0] rom_entry(input logic [4:0] idx);
        logic [5:0] e;
        case (idx)
            5'd0:    e = {4'd1, C_DUR3};
            5'd1:    e = {4'd1, C_DUR1};
            5'd2:    e = {4'd2, C_DUR4};
            5'd3:    e = {4'd1, C_DUR4};
            5'd4:    e = {4'd4, C_DUR4};
            5'd5:    e = {4'd3, C_DUR8};
            5'd6:    e = {4'd1, C_DUR3};
            5'd7:    e = {4'd1, C_DUR1};
            5'd8:    e = {4'd2, C_DUR4};
            5'd9:    e = {4'd1, C_DUR4};
            5'd10:   e = {4'd5, C_DUR4};
            5'd11:   e = {4'd4, C_DUR8};
            5'd12:   e = {4'd1, C_DUR3};
            5'd13:   e = {4'd1, C_DUR1};
            5'd14:   e = {4'd8, C_DUR4};
            5'd15:   e = {4'd6, C_DUR4};
            5'd16:   e = {4'd4, C_DUR4};
            5'd17:   e = {4'd3, C_DUR4};
            5'd18:   e = {4'd2, C_DUR8};
            5'd19:   e = {4'd7, C_DUR3};
            5'd20:   e = {4'd7, C_DUR1};
            5'd21:   e = {4'd6, C_DUR4};
            5'd22:   e = {4'd4, C_DUR4};
            5'd23:   e = {4'd5, C_DUR4};
            5'd24:   e = {4'd4, C_DUR8};
            default: e = 6'd0;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] onehot(input logic [3:0] code);
        logic [7:0] v;
        if (code == 4'd0 || code > 4'd8) begin
            v = 8'h00;
        end else begin
            v = 8'h01 << (code - 4'd1);
        end
        return v;
    endfunction

    function automatic logic [C_CNT_W-1:0] tone_last(input logic [1:0] dur);
        logic [C_CNT_W-1:0] t;
        case (dur)
            C_DUR1:  t = C_TONE1_LAST;
            C_DUR3:  t = C_TONE3_LAST;
            C_DUR4:  t = C_TONE4_LAST;
            default: t = C_TONE8_LAST;
        endcase
        return t;
    endfunction

    state_t             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]         note_idx_q, note_idx_d;
    logic [7:0]         pitch_en_q, pitch_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               w_loop_req;
    logic [5:0]         w_cur_entry;
    logic [5:0]         w_nxt_entry;
    logic [5:0]         w_first_entry;
    logic [4:0]         w_next_idx;

`ifdef SONG_LOOP_EN
    assign w_loop_req = loop;
`else
    assign w_loop_req = 1'b0;
`endif

    assign w_next_idx    = note_idx_q + 5'd1;
    assign w_cur_entry   = rom_entry(note_idx_q);
    assign w_nxt_entry   = rom_entry(w_next_idx);
    assign w_first_entry = rom_entry(5'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        note_idx_d = note_idx_q;
        pitch_en_d = pitch_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        if (stop) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            note_idx_d = 5'd0;
            pitch_en_d = 8'h00;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pitch_en_d = 8'h00;
                    busy_d     = 1'b0;
                    note_idx_d = 5'd0;
                    if (start) begin
                        state_d    = S_TONE;
                        cnt_d      = '0;
                        pitch_en_d = onehot(w_first_entry[5:2]);
                        busy_d     = 1'b1;
                    end
                end
                S_TONE: begin
                    if (cnt_q == tone_last(w_cur_entry[1:0])) begin
                        state_d    = S_GAP;
                        cnt_d      = '0;
                        pitch_en_d = 8'h00;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == C_GAP_LAST) begin
                        cnt_d = '0;
                        if (note_idx_q != C_LAST_NOTE) begin
                            state_d    = S_TONE;
                            note_idx_d = w_next_idx;
                            pitch_en_d = onehot(w_nxt_entry[5:2]);
                        end else begin
                            done_d     = 1'b1;
                            note_idx_d = 5'd0;
                            if (w_loop_req) begin
                                state_d    = S_TONE;
                                pitch_en_d = onehot(w_first_entry[5:2]);
                                busy_d     = 1'b1;
                            end else begin
                                state_d    = S_IDLE;
                                pitch_en_d = 8'h00;
                                busy_d     = 1'b0;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    note_idx_d = 5'd0;
                    pitch_en_d = 8'h00;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    // Asynchronous reset clears pitch_en at once so no divider sees a stray enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            note_idx_q <= 5'd0;
            pitch_en_q <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            note_idx_q <= note_idx_d;
            pitch_en_q <= pitch_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign pitch_en = pitch_en_q;
    assign note_idx = note_idx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire
